// File: rtl/init_number_pipe.sv
// Two-stage operand-alignment front end for FP add/sub: exponent compare, mantissa
// right-shift with sticky, magnitude ordering and sign rule, with valid/ready on both sides.
module init_number_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             sign_A,
    input  logic             sign_B,
    input  logic [EXP_W-1:0] exp_A,
    input  logic [EXP_W-1:0] exp_B,
    input  logic [MAN_W-1:0] mantis_A,
    input  logic [MAN_W-1:0] mantis_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_of_great,
    output logic             sign_of_small,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] mantis_great,
    output logic [MAN_W-1:0] mantis_small,
    output logic             sticky,
    output logic             equal,
    output logic             eff_sub
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic             sign_a;
        logic             sign_b;    // already includes op_sub
        logic             shift_b;   // 1: B is the shifted operand, A is the non-shifted one
        logic [EXP_W-1:0] exp_max;
        logic [EXP_W-1:0] diff;
        logic [MAN_W-1:0] shift_man;
        logic [MAN_W-1:0] non_man;
    } s1_t;

    logic [STAGES:1] vld_pipe;
    logic            s1_adv, s2_adv;
    s1_t             s1_d, s1_q;

    assign s2_adv    = ~vld_pipe[2] | out_ready;
    assign s1_adv    = ~vld_pipe[1] | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe[2];

    // Stage 1: exponent compare and operand steering
    always_comb begin
        s1_d         = '0;
        s1_d.sign_a  = sign_A;
        s1_d.sign_b  = sign_B ^ op_sub;
        s1_d.shift_b = (exp_A >= exp_B);
        if (s1_d.shift_b) begin
            s1_d.exp_max   = exp_A;
            s1_d.diff      = exp_A - exp_B;
            s1_d.shift_man = mantis_B;
            s1_d.non_man   = mantis_A;
        end else begin
            s1_d.exp_max   = exp_B;
            s1_d.diff      = exp_B - exp_A;
            s1_d.shift_man = mantis_A;
            s1_d.non_man   = mantis_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            s1_q        <= '0;
        end else if (s1_adv) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    // Stage 2: alignment shift, sticky, ordering
    logic             full_shift;
    logic [MAN_W-1:0] shifted, out_mask;
    logic             st;
    logic             mag_gt, mag_eq;
    logic             sign_shift, sign_non;
    logic             great_is_shift;

    always_comb begin
        full_shift = (int'(s1_q.diff) >= MAN_W);
        shifted    = full_shift ? '0 : (s1_q.shift_man >> s1_q.diff);
        out_mask   = full_shift ? '1 : ~({MAN_W{1'b1}} << s1_q.diff);
        st         = |(s1_q.shift_man & out_mask);
        mag_gt     = {shifted, st} >  {s1_q.non_man, 1'b0};
        mag_eq     = {shifted, st} == {s1_q.non_man, 1'b0};
        sign_shift = s1_q.shift_b ? s1_q.sign_b : s1_q.sign_a;
        sign_non   = s1_q.shift_b ? s1_q.sign_a : s1_q.sign_b;
        // Tie: the positive operand wins when signs differ, otherwise A wins
        if (!mag_eq)                    great_is_shift = mag_gt;
        else if (sign_shift != sign_non) great_is_shift = ~sign_shift;
        else                             great_is_shift = ~s1_q.shift_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[2]   <= 1'b0;
            sign_of_great <= 1'b0;
            sign_of_small <= 1'b0;
            exp           <= '0;
            mantis_great  <= '0;
            mantis_small  <= '0;
            sticky        <= 1'b0;
            equal         <= 1'b0;
            eff_sub       <= 1'b0;
        end else if (s2_adv) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                sign_of_great <= great_is_shift ? sign_shift : sign_non;
                sign_of_small <= great_is_shift ? sign_non : sign_shift;
                exp           <= s1_q.exp_max;
                mantis_great  <= great_is_shift ? shifted : s1_q.non_man;
                mantis_small  <= great_is_shift ? s1_q.non_man : shifted;
                sticky        <= st;
                equal         <= mag_eq;
                eff_sub       <= sign_shift ^ sign_non;
            end
        end
    end

endmodule

// File: tb/tb_init_number_pipe.sv
// Randomized scoreboard bench for init_number_pipe plus directed alignment, stall and reset cases.
module tb_init_number_pipe;
    localparam int EW = 8;
    localparam int MW = 28;

    typedef struct packed {
        logic          op, sa, sb;
        logic [EW-1:0] ea, eb;
        logic [MW-1:0] ma, mb;
    } in_t;

    typedef struct packed {
        logic          sg, ss;
        logic [EW-1:0] e;
        logic [MW-1:0] mg, ms;
        logic          st, eq, es;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, op_sub, sign_A, sign_B;
    logic [EW-1:0] exp_A, exp_B, exp;
    logic [MW-1:0] mantis_A, mantis_B, mantis_great, mantis_small;
    logic out_valid, out_ready, sign_of_great, sign_of_small, sticky, equal, eff_sub;

    always #5 clk = ~clk;

    init_number_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .sign_A(sign_A), .sign_B(sign_B),
        .exp_A(exp_A), .exp_B(exp_B), .mantis_A(mantis_A), .mantis_B(mantis_B),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_of_great(sign_of_great), .sign_of_small(sign_of_small), .exp(exp),
        .mantis_great(mantis_great), .mantis_small(mantis_small),
        .sticky(sticky), .equal(equal), .eff_sub(eff_sub)
    );

    int   n_chk = 0, n_err = 0, n_out = 0;
    res_t q[$];
    logic rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: align both magnitudes to a common exponent (x2 plus sticky), then pick by rule
    function automatic res_t model(input in_t t);
        res_t r;
        logic sbe;
        bit a_big, a_great;
        int d;
        longint unsigned sm, sh, mag_a, mag_b;
        bit st;
        sbe   = t.sb ^ t.op;
        a_big = (t.ea >= t.eb);
        d     = a_big ? int'(t.ea) - int'(t.eb) : int'(t.eb) - int'(t.ea);
        sm    = a_big ? longint'(t.mb) : longint'(t.ma);
        if (d >= MW) begin sh = 0; st = (sm != 0); end
        else begin sh = sm >> d; st = ((sh << d) != sm); end
        mag_a = a_big ? longint'(t.ma) * 2 : sh * 2 + longint'(st);
        mag_b = a_big ? sh * 2 + longint'(st) : longint'(t.mb) * 2;
        if (mag_a != mag_b)   a_great = (mag_a > mag_b);
        else if (t.sa != sbe) a_great = !t.sa;
        else                  a_great = 1'b1;
        r.e  = a_big ? t.ea : t.eb;
        r.mg = MW'((a_great ? mag_a : mag_b) >> 1);
        r.ms = MW'((a_great ? mag_b : mag_a) >> 1);
        r.sg = a_great ? t.sa : sbe;
        r.ss = a_great ? sbe : t.sa;
        r.st = st;
        r.eq = (mag_a == mag_b);
        r.es = r.sg ^ r.ss;
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r = '{sign_of_great, sign_of_small, exp, mantis_great, mantis_small, sticky, equal, eff_sub};
        return r;
    endfunction

    // Scoreboard and stall-hold monitor, sampled mid-cycle
    res_t prev;
    bit   held = 0;
    always @(negedge clk) begin
        res_t e, o;
        if (rst) begin
            q.delete();
            held = 0;
        end else begin
            o = dut_res();
            if (held) chk("hold", 64'(o), 64'(prev));
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", 64'(1), 64'(0));
                else begin
                    e = q.pop_front();
                    chk("exp",  64'(o.e),  64'(e.e));
                    chk("mg",   64'(o.mg), 64'(e.mg));
                    chk("ms",   64'(o.ms), 64'(e.ms));
                    chk("sg",   64'(o.sg), 64'(e.sg));
                    chk("ss",   64'(o.ss), 64'(e.ss));
                    chk("st",   64'(o.st), 64'(e.st));
                    chk("eq",   64'(o.eq), 64'(e.eq));
                    chk("es",   64'(o.es), 64'(e.es));
                end
                n_out++;
            end
            if (in_valid && in_ready)
                q.push_back(model('{op_sub, sign_A, sign_B, exp_A, exp_B, mantis_A, mantis_B}));
            held = out_valid && !out_ready;
            prev = o;
        end
    end

    always @(posedge clk) if (rnd_rdy) begin #1; out_ready = ($urandom_range(0, 3) != 0); end

    task automatic drive(input in_t t);
        op_sub = t.op; sign_A = t.sa; sign_B = t.sb;
        exp_A = t.ea; exp_B = t.eb; mantis_A = t.ma; mantis_B = t.mb;
    endtask

    task automatic push(input in_t t);
        logic acc;
        int   n;
        drive(t);
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk) acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 60);
        if (!acc) chk("push_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic one(input in_t t);
        int lat;
        out_ready = 1'b1;
        push(t);
        lat = 1;
        while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        chk("latency", 64'(lat), 64'(2));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
        chk("drain", 64'(q.size()), 64'(0));
    endtask

    function automatic in_t rnd_in();
        in_t t;
        int  eb;
        t.op = 1'($urandom); t.sa = 1'($urandom); t.sb = 1'($urandom);
        t.ea = EW'($urandom);
        eb   = ($urandom_range(0, 3) == 0) ? int'(t.ea) : int'(t.ea) + int'($urandom_range(0, 70)) - 35;
        if (eb < 0) eb = 0;
        if (eb > 255) eb = 255;
        t.eb = EW'(eb);
        t.ma = MW'($urandom);
        t.mb = ($urandom_range(0, 3) == 0) ? MW'($urandom_range(0, 255)) : MW'($urandom);
        if ($urandom_range(0, 4) == 0) begin t.eb = t.ea; t.mb = t.ma; end
        return t;
    endfunction

    initial begin
        int n0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive('0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk("rst_outs",      64'(dut_res()), 64'(0));

        // 1: plain alignment by 2
        one('{1'b0, 1'b0, 1'b0, 8'h82, 8'h80, 28'h8000000, 28'hC000000});
        chk("t1_exp", 64'(exp), 64'h82);
        chk("t1_mg",  64'(mantis_great), 64'h8000000);
        chk("t1_ms",  64'(mantis_small), 64'h3000000);
        chk("t1_st",  64'(sticky), 64'(0));
        chk("t1_es",  64'(eff_sub), 64'(0));
        @(posedge clk); #1;
        // 2: bits shifted out set sticky
        one('{1'b0, 1'b0, 1'b0, 8'h82, 8'h80, 28'h8000000, 28'h0000007});
        chk("t2_ms", 64'(mantis_small), 64'h1);
        chk("t2_st", 64'(sticky), 64'(1));
        @(posedge clk); #1;
        // 3: shift distance beyond mantissa width
        one('{1'b0, 1'b0, 1'b0, 8'hA0, 8'h80, 28'h8000000, 28'h0000001});
        chk("t3_ms",  64'(mantis_small), 64'(0));
        chk("t3_st",  64'(sticky), 64'(1));
        chk("t3_exp", 64'(exp), 64'hA0);
        @(posedge clk); #1;
        // 4: tie with opposite signs, both as add and as subtract
        for (int k = 0; k < 2; k++) begin
            one('{k[0], 1'b1, k[0], 8'h90, 8'h90, 28'h5000000, 28'h5000000});
            chk("t4_eq", 64'(equal), 64'(1));
            chk("t4_sg", 64'(sign_of_great), 64'(0));
            chk("t4_ss", 64'(sign_of_small), 64'(1));
            chk("t4_es", 64'(eff_sub), 64'(1));
            @(posedge clk); #1;
        end

        // 5: back-to-back with downstream stalled
        n0 = n_out;
        out_ready = 1'b0;
        push(rnd_in());
        push(rnd_in());
        drive(rnd_in());
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_in_ready", 64'(in_ready), 64'(0));
            chk("t5_out_valid", 64'(out_valid), 64'(1));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        push('{op_sub, sign_A, sign_B, exp_A, exp_B, mantis_A, mantis_B});
        push(rnd_in());
        drain();
        chk("t5_count", 64'(n_out - n0), 64'(4));

        // 6: reset with two transactions in flight
        out_ready = 1'b0;
        push(rnd_in());
        push(rnd_in());
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_out_valid", 64'(out_valid), 64'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (4) @(posedge clk);
        #1 chk("t6_no_emit", 64'(n_out - n0), 64'(0));
        drive(rnd_in());
        in_valid = 1'b1;
        @(negedge clk) chk("t6_accept", 64'(in_ready), 64'(1));
        @(posedge clk); #1 in_valid = 1'b0;
        drain();
        chk("t6_count", 64'(n_out - n0), 64'(1));

        // Random traffic with random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            push(rnd_in());
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #2;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
